// File: rtl/clk_div_multi_if.sv
// Control/status bundle for the multi-channel clock divider: run requests,
// divisor writes and sync strobe in; divided clocks, ticks and busy flags out.
interface clk_div_multi_if #(
    parameter int NCH   = 4,
    parameter int DIV_W = 8
);
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]   en;
    logic             div_wr;
    logic [SEL_W-1:0] div_sel;
    logic [DIV_W-1:0] div_data;
    logic             sync;
    logic [NCH-1:0]   div_clk;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   div_busy;

    modport master (
        output en, div_wr, div_sel, div_data, sync,
        input  div_clk, tick, div_busy
    );

    modport slave (
        input  en, div_wr, div_sel, div_data, sync,
        output div_clk, tick, div_busy
    );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider; divisor and run changes only land
// on period boundaries so the divided outputs never glitch.
//   state | meaning
//   IDLE  | stopped, cnt=0, div_clk=0
//   RUN   | counting, run request held
//   STOP  | run request dropped, finishing current period
module clk_div_multi #(
    parameter int             NCH      = 4,
    parameter int             DIV_W    = 8,
    parameter int             DIV_INIT = 2,
    parameter logic [NCH-1:0] PULSE    = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    clk_div_multi_if.slave bus
);
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t           state    [NCH];
    state_t           state_nx [NCH];
    logic [DIV_W-1:0] cnt      [NCH];
    logic [DIV_W-1:0] cnt_nx   [NCH];
    logic [DIV_W-1:0] active   [NCH];
    logic [DIV_W-1:0] active_nx[NCH];
    logic [DIV_W-1:0] pending   [NCH];
    logic [DIV_W-1:0] pending_nx[NCH];
    logic [NCH-1:0]   clk_q, clk_nx;
    logic [NCH-1:0]   tick_q, tick_nx;
    logic [NCH-1:0]   busy_q, busy_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                state[c]   <= IDLE;
                cnt[c]     <= '0;
                active[c]  <= DIV_W'(DIV_INIT);
                pending[c] <= DIV_W'(DIV_INIT);
            end
            clk_q  <= '0;
            tick_q <= '0;
            busy_q <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            active  <= active_nx;
            pending <= pending_nx;
            clk_q   <= clk_nx;
            tick_q  <= tick_nx;
            busy_q  <= busy_nx;
        end
    end

    logic             wr_hit, wrap, running, resync, apply;
    logic [DIV_W:0]   div_eff, high;
    logic [DIV_W-1:0] last, cnt_inc;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        active_nx  = active;
        pending_nx = pending;
        clk_nx     = clk_q;
        tick_nx    = tick_q;
        busy_nx    = busy_q;
        wr_hit     = 1'b0;
        wrap       = 1'b0;
        running    = 1'b0;
        resync     = 1'b0;
        apply      = 1'b0;
        div_eff    = '0;
        high       = '0;
        last       = '0;
        cnt_inc    = '0;
        for (int c = 0; c < NCH; c++) begin
            wr_hit  = bus.div_wr && (bus.div_sel == SEL_W'(c));
            // divisors 0 and 1 run as 2; the extra bit keeps ceil(D/2) from overflowing at max N
            div_eff = (active[c] < DIV_W'(2)) ? (DIV_W+1)'(2) : {1'b0, active[c]};
            last    = DIV_W'(div_eff - (DIV_W+1)'(1));
            high    = PULSE[c] ? (DIV_W+1)'(1) : ((div_eff + (DIV_W+1)'(1)) >> 1);
            wrap    = (cnt[c] == last);
            cnt_inc = wrap ? '0 : cnt[c] + DIV_W'(1);
            running = (state[c] != IDLE);
            resync  = running && bus.sync;
            apply   = (!running && bus.en[c]) || resync || (running && wrap);

            if (!running) begin
                cnt_nx[c]  = '0;
                clk_nx[c]  = bus.en[c];
                tick_nx[c] = 1'b0;
                if (bus.en[c]) state_nx[c] = RUN;
            end else begin
                if (bus.sync) begin
                    cnt_nx[c]  = '0;
                    clk_nx[c]  = 1'b1;
                    tick_nx[c] = 1'b0;
                end else begin
                    cnt_nx[c]  = cnt_inc;
                    clk_nx[c]  = ({1'b0, cnt_inc} < high);
                    tick_nx[c] = (cnt_inc == last);
                end
                if (state[c] == RUN) begin
                    if (!bus.en[c]) state_nx[c] = STOP;
                end else if (bus.en[c]) begin
                    state_nx[c] = RUN;
                end else if (wrap && !bus.sync) begin
                    state_nx[c] = IDLE;
                    clk_nx[c]   = 1'b0;
                end
            end

            // a write coinciding with sync is applied directly; with a wrap it waits one period
            if (apply) begin
                if (wr_hit && resync) begin
                    active_nx[c]  = bus.div_data;
                    pending_nx[c] = bus.div_data;
                    busy_nx[c]    = 1'b0;
                end else begin
                    active_nx[c] = pending[c];
                    busy_nx[c]   = wr_hit;
                    if (wr_hit) pending_nx[c] = bus.div_data;
                end
            end else if (wr_hit) begin
                pending_nx[c] = bus.div_data;
                busy_nx[c]    = 1'b1;
            end
        end
    end

    assign bus.div_clk  = clk_q;
    assign bus.tick     = tick_q;
    assign bus.div_busy = busy_q;
endmodule
